riscv_writeback_unit: RTL

Writeback stage of the 64-bit RISC-V datapath. It accepts completed instructions from the execute/memory stage over a valid/ready handshake and selects the writeback value: ALU result, PC+4, or load data. Load data waits for a data-memory response and is byte-aligned and sign- or zero-extended. The selected value is then driven into the register file's write port as a single-cycle write. The block also publishes its in-flight destination register for hazard detection, and flags memory responses that never arrive.

---
 rtl/riscv_writeback_unit.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/riscv_writeback_unit.sv
// Writeback stage: selects ALU / PC+4 / aligned-and-extended load data and
// drives a single-cycle register-file write, with a bounded wait for load data.
module riscv_writeback_unit #(
    parameter int XLEN    = 64,
    parameter int TIMEOUT = 15
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            in_reg_write,
    input  logic [4:0]      in_rd,
    input  logic [1:0]      in_wb_sel,
    input  logic [2:0]      in_funct3,
    input  logic [XLEN-1:0] in_alu_result,
    input  logic [XLEN-1:0] in_pc_plus4,
    input  logic            mem_rsp_valid,
    input  logic [XLEN-1:0] mem_rsp_data,
    output logic            wb_reg_write,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_write_data,
    output logic            pending_valid,
    output logic [4:0]      pending_rd,
    output logic            err_timeout
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_MEM,
        WRITE
    } state_t;

    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

    state_t          state, state_next;
    logic [4:0]      rd_q, rd_d;
    logic            reg_write_q, reg_write_d;
    logic [2:0]      funct3_q, funct3_d;
    logic [2:0]      addr_q, addr_d;
    logic [7:0]      wait_cnt_q, wait_cnt_d;
    logic [XLEN-1:0] data_d;
    logic            err_d;
    logic            transfer;
    logic            write_en_d;

    // Align the addressed byte to bit 0, then extend according to the load width.
    function automatic logic [XLEN-1:0] load_extend(input logic [XLEN-1:0] data,
                                                    input logic [2:0]      offset,
                                                    input logic [2:0]      funct3);
        logic [XLEN-1:0] shifted;
        shifted = data >> {offset, 3'b000};
        case (funct3)
            3'b000:  return {{(XLEN-8){shifted[7]}},   shifted[7:0]};
            3'b001:  return {{(XLEN-16){shifted[15]}}, shifted[15:0]};
            3'b010:  return {{(XLEN-32){shifted[31]}}, shifted[31:0]};
            3'b100:  return {{(XLEN-8){1'b0}},         shifted[7:0]};
            3'b101:  return {{(XLEN-16){1'b0}},        shifted[15:0]};
            3'b110:  return {{(XLEN-32){1'b0}},        shifted[31:0]};
            default: return shifted;
        endcase
    endfunction

    assign in_ready = (state != WAIT_MEM);
    assign transfer = in_valid && in_ready;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
        state_next  = state;
        rd_d        = rd_q;
        reg_write_d = reg_write_q;
        funct3_d    = funct3_q;
        addr_d      = addr_q;
        wait_cnt_d  = wait_cnt_q;
        data_d      = '0;
        err_d       = 1'b0;

        case (state)
            IDLE, WRITE: begin
                if (transfer) begin
                    rd_d        = in_rd;
                    reg_write_d = in_reg_write;
                    funct3_d    = in_funct3;
                    addr_d      = in_alu_result[2:0];
                    if (in_wb_sel == 2'b01) begin
                        wait_cnt_d = '0;
                        state_next = WAIT_MEM;
                    end else begin
                        data_d     = (in_wb_sel == 2'b10) ? in_pc_plus4 : in_alu_result;
                        state_next = WRITE;
                    end
                end else begin
                    state_next = IDLE;
                end
            end
            WAIT_MEM: begin
                // A response on the timeout edge still completes the load.
                if (mem_rsp_valid) begin
                    data_d     = load_extend(mem_rsp_data, addr_q, funct3_q);
                    state_next = WRITE;
                end else if (wait_cnt_q == TIMEOUT_LAST) begin
                    err_d      = 1'b1;
                    state_next = IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign write_en_d = reg_write_d && (rd_d != 5'd0);

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state         <= IDLE;
            rd_q          <= '0;
            reg_write_q   <= 1'b0;
            funct3_q      <= '0;
            addr_q        <= '0;
            wait_cnt_q    <= '0;
            wb_reg_write  <= 1'b0;
            wb_rd         <= '0;
            wb_write_data <= '0;
            pending_valid <= 1'b0;
            pending_rd    <= '0;
            err_timeout   <= 1'b0;
        end else begin
            state         <= state_next;
            rd_q          <= rd_d;
            reg_write_q   <= reg_write_d;
            funct3_q      <= funct3_d;
            addr_q        <= addr_d;
            wait_cnt_q    <= wait_cnt_d;
            wb_reg_write  <= (state_next == WRITE) && write_en_d;
            if (state_next == WRITE) begin
                wb_rd         <= rd_d;
                wb_write_data <= data_d;
            end
            pending_valid <= (state_next != IDLE) && write_en_d;
            pending_rd    <= rd_d;
            err_timeout   <= err_d;
        end
    end

endmodule
